mcb_port_arbiter: RTL and testbench

- Time-shares one MCB port between the display read engine and two capture write engines (left/right eye).
- Grants exactly one requester at a time via a memcon_en-style enable/done handshake.
- Publishes ownership on arb_state; the read engine only issues commands while arb_state == 2'b00.
- Sits in the memclk domain between the video read/write engines and the MCB command port.

---
 rtl/mcb_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mcb_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_port_arbiter.sv
// Time-shares one MCB command port between the display reader and two capture writers.
// One-cycle grant latency; owners hold the port until done/timeout; GUARD waits on mcb_cmd_empty.
module mcb_port_arbiter #(
   parameter int GUARD_CYC = 4,
   parameter int TIMEOUT   = 2048,
   parameter int MAX_WAIT  = 512,
   parameter int CW        = 12
) (
   input  logic       memclk,
   input  logic       rst_n,
   input  logic       rd_req,
   input  logic       rd_done,
   output logic       rd_en,
   input  logic       wr0_req,
   input  logic       wr0_done,
   output logic       wr0_en,
   input  logic       wr1_req,
   input  logic       wr1_done,
   output logic       wr1_en,
   input  logic       mcb_cmd_empty,
   output logic [1:0] arb_state,
   output logic       timeout_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      GRANT_RD,
      GRANT_W0,
      GRANT_W1,
      GUARD
   } state_t;

   localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WAIT_MAX     = CW'(MAX_WAIT);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] wait0, wait0_nxt;
   logic [CW-1:0] wait1, wait1_nxt;
   logic          rr, rr_nxt;
   logic          sat0, sat1, pick_w1, owner_done, terr_set;
   logic [1:0]    arb_nxt;

   always_ff @(posedge memclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      rr_nxt     = rr;
      pick_w1    = 1'b0;
      owner_done = 1'b0;
      terr_set   = 1'b0;
      sat0       = wr0_req && (wait0 == WAIT_MAX);
      sat1       = wr1_req && (wait1 == WAIT_MAX);

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            // Starved writers outrank the reader; rr breaks every writer tie.
            if (sat0 || sat1) begin
               pick_w1   = (sat0 && sat1) ? rr : sat1;
               state_nxt = pick_w1 ? GRANT_W1 : GRANT_W0;
               rr_nxt    = ~pick_w1;
            end else if (rd_req) begin
               state_nxt = GRANT_RD;
            end else if (wr0_req || wr1_req) begin
               pick_w1   = (wr0_req && wr1_req) ? rr : wr1_req;
               state_nxt = pick_w1 ? GRANT_W1 : GRANT_W0;
               rr_nxt    = ~pick_w1;
            end
         end

         GRANT_RD, GRANT_W0, GRANT_W1: begin
            owner_done = ((state == GRANT_RD) && rd_done) ||
                         ((state == GRANT_W0) && wr0_done) ||
                         ((state == GRANT_W1) && wr1_done);
            if (owner_done) begin
               state_nxt = GUARD;
               cnt_nxt   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt = GUARD;
               cnt_nxt   = '0;
               terr_set  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         GUARD: begin
            // Counter parks at GUARD_LAST so a long non-empty FIFO cannot wrap it.
            if (cnt == GUARD_LAST) begin
               if (mcb_cmd_empty) begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      wait0_nxt = '0;
      wait1_nxt = '0;
      if (wr0_req && (state != GRANT_W0)) begin
         wait0_nxt = (wait0 == WAIT_MAX) ? wait0 : wait0 + 1'b1;
      end
      if (wr1_req && (state != GRANT_W1)) begin
         wait1_nxt = (wait1 == WAIT_MAX) ? wait1 : wait1 + 1'b1;
      end
   end

   always_comb begin
      arb_nxt = 2'b11;
      case (state_nxt)
         GRANT_RD: arb_nxt = 2'b00;
         GRANT_W0: arb_nxt = 2'b01;
         GRANT_W1: arb_nxt = 2'b10;
         default:  arb_nxt = 2'b11;
      endcase
   end

   // Outputs come straight from flops so the engines see glitch-free enables.
   always_ff @(posedge memclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         wait0       <= '0;
         wait1       <= '0;
         rr          <= 1'b0;
         rd_en       <= 1'b0;
         wr0_en      <= 1'b0;
         wr1_en      <= 1'b0;
         arb_state   <= 2'b11;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         wait0       <= wait0_nxt;
         wait1       <= wait1_nxt;
         rr          <= rr_nxt;
         rd_en       <= (state_nxt == GRANT_RD);
         wr0_en      <= (state_nxt == GRANT_W0);
         wr1_en      <= (state_nxt == GRANT_W1);
         arb_state   <= arb_nxt;
         busy        <= (state_nxt != IDLE);
         timeout_err <= timeout_err | terr_set;
      end
   end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Directed + randomized bench for mcb_port_arbiter against a cycle-level ownership model.
module tb_mcb_port_arbiter;
   localparam int GUARD_CYC = 4;
   localparam int TIMEOUT   = 2048;
   localparam int MAX_WAIT  = 512;

   logic       memclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd_req = 1'b0, rd_done = 1'b0;
   logic       wr0_req = 1'b0, wr0_done = 1'b0;
   logic       wr1_req = 1'b0, wr1_done = 1'b0;
   logic       mcb_cmd_empty = 1'b1;
   logic       rd_en, wr0_en, wr1_en, timeout_err, busy;
   logic [1:0] arb_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: owner -1 none / 0 rd / 1 wr0 / 2 wr1; phase 0 idle / 1 granted / 2 guard.
   int m_owner, m_phase, m_age, m_next_wr;
   int m_wait[2];
   bit m_terr;

   mcb_port_arbiter dut (
      .memclk(memclk), .rst_n(rst_n),
      .rd_req(rd_req), .rd_done(rd_done), .rd_en(rd_en),
      .wr0_req(wr0_req), .wr0_done(wr0_done), .wr0_en(wr0_en),
      .wr1_req(wr1_req), .wr1_done(wr1_done), .wr1_en(wr1_en),
      .mcb_cmd_empty(mcb_cmd_empty), .arb_state(arb_state),
      .timeout_err(timeout_err), .busy(busy)
   );

   always #5 memclk = ~memclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_owner = -1; m_phase = 0; m_age = 0; m_next_wr = 0;
      m_wait[0] = 0; m_wait[1] = 0; m_terr = 1'b0;
   endfunction

   function automatic void model_edge();
      int nw0, nw1, pick;
      bit s0, s1, d;
      nw0 = (!wr0_req || m_owner == 1) ? 0 : ((m_wait[0] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[0] + 1);
      nw1 = (!wr1_req || m_owner == 2) ? 0 : ((m_wait[1] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[1] + 1);
      if (m_phase == 0) begin
         pick = -1;
         s0 = wr0_req && (m_wait[0] >= MAX_WAIT);
         s1 = wr1_req && (m_wait[1] >= MAX_WAIT);
         if (s0 && s1) pick = m_next_wr + 1;
         else if (s0) pick = 1;
         else if (s1) pick = 2;
         else if (rd_req) pick = 0;
         else if (wr0_req && wr1_req) pick = m_next_wr + 1;
         else if (wr0_req) pick = 1;
         else if (wr1_req) pick = 2;
         if (pick >= 0) begin
            m_owner = pick; m_phase = 1; m_age = 0;
            if (pick == 1) m_next_wr = 1;
            if (pick == 2) m_next_wr = 0;
         end
      end else if (m_phase == 1) begin
         d = (m_owner == 0 && rd_done) || (m_owner == 1 && wr0_done) || (m_owner == 2 && wr1_done);
         if (d || m_age == TIMEOUT - 1) begin
            if (!d) m_terr = 1'b1;
            m_phase = 2; m_owner = -1; m_age = 0;
         end else begin
            m_age++;
         end
      end else begin
         if (m_age >= GUARD_CYC - 1 && mcb_cmd_empty) m_phase = 0;
         else m_age++;
      end
      m_wait[0] = nw0;
      m_wait[1] = nw1;
   endfunction

   function automatic logic [6:0] model_outs();
      logic [6:0] v;
      v[6]   = (m_owner == 0);
      v[5]   = (m_owner == 1);
      v[4]   = (m_owner == 2);
      v[3:2] = (m_owner < 0) ? 2'b11 : 2'(m_owner);
      v[1]   = (m_phase != 0);
      v[0]   = m_terr;
      return v;
   endfunction

   task automatic step();
      @(posedge memclk);
      model_edge();
      cyc++;
      #1;
      check("cycle", {rd_en, wr0_en, wr1_en, arb_state, busy, timeout_err}, model_outs());
   endtask

   task automatic wait_grant(input string tag, input int budget, output int n);
      n = 0;
      while ((rd_en | wr0_en | wr1_en) !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(tag, rd_en | wr0_en | wr1_en, 1);
   endtask

   // Keeps the current grant for n cycles in total, then pulses the owner's done.
   task automatic hold_done(input int n);
      int who;
      who = (rd_en === 1'b1) ? 0 : (wr0_en === 1'b1) ? 1 : 2;
      repeat (n - 1) step();
      case (who)
         0: rd_done = 1'b1;
         1: wr0_done = 1'b1;
         default: wr1_done = 1'b1;
      endcase
      step();
      rd_done = 1'b0; wr0_done = 1'b0; wr1_done = 1'b0;
   endtask

   initial begin
      int n, start;
      logic [1:0] exp_st;
      model_reset();
      #12;
      check("reset_outs", {rd_en, wr0_en, wr1_en, arb_state, busy, timeout_err}, 7'b0001100);
      #10 rst_n = 1'b1;

      repeat (100) step();
      check("idle100", {rd_en, wr0_en, wr1_en, busy, arb_state}, 6'b000011);

      rd_req = 1'b1;
      step();
      check("rd_latency", {rd_en, arb_state}, 3'b100);
      hold_done(50);
      check("rd_drop", {rd_en, arb_state}, 3'b011);
      wait_grant("rd_regrant_wait", 20, n);
      check("guard_gap", n, GUARD_CYC + 1);
      rd_req = 1'b0;
      hold_done(10);
      repeat (10) step();

      wr0_req = 1'b1; wr1_req = 1'b1;
      for (int g = 0; g < 4; g++) begin
         wait_grant("alt_wait", 30, n);
         exp_st = (g % 2 == 0) ? 2'b01 : 2'b10;
         check("alt_owner", arb_state, exp_st);
         hold_done(20);
      end
      wr0_req = 1'b0; wr1_req = 1'b0;
      repeat (10) step();

      rd_req = 1'b1; wr1_req = 1'b1;
      start = cyc;
      for (int k = 0; k < 10; k++) begin
         wait_grant("starve_wait", 30, n);
         if (rd_en !== 1'b1) break;
         hold_done(100);
      end
      check("starve_owner", arb_state, 2'b10);
      check("starve_window", (cyc - start > MAX_WAIT) && (cyc - start <= MAX_WAIT + 110), 1);
      rd_req = 1'b0; wr1_req = 1'b0;
      hold_done(20);
      repeat (10) step();

      wr1_req = 1'b1;
      wait_grant("tmo_same_wait", 30, n);
      wr1_req = 1'b0;
      hold_done(TIMEOUT);
      check("tmo_same_cycle_done", {wr1_en, busy, timeout_err}, 3'b010);
      repeat (10) step();

      wr0_req = 1'b1;
      wait_grant("tmo_wait", 30, n);
      wr0_req = 1'b0;
      n = 0;
      while (wr0_en === 1'b1 && n < TIMEOUT + 10) begin
         step();
         n++;
      end
      check("tmo_len", n, TIMEOUT);
      check("tmo_err", timeout_err, 1);
      repeat (10) step();
      check("tmo_sticky", timeout_err, 1);
      rd_req = 1'b1;
      wait_grant("tmo_rd_wait", 30, n);
      check("tmo_rd_owner", arb_state, 2'b00);
      rd_req = 1'b0;
      hold_done(5);
      repeat (10) step();

      wr0_req = 1'b1;
      wait_grant("stray_wait", 30, n);
      wr0_req = 1'b0;
      repeat (5) step();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      check("stray_rd_done", {wr0_en, arb_state}, 3'b101);
      repeat (3) step();
      mcb_cmd_empty = 1'b0; rd_req = 1'b1; wr0_done = 1'b1;
      step();
      wr0_done = 1'b0;
      check("w0_drop", wr0_en, 0);
      repeat (20) step();
      check("guard_hold", {rd_en, wr0_en, wr1_en, busy, arb_state}, 6'b000111);
      mcb_cmd_empty = 1'b1;
      wait_grant("guard_release_wait", 10, n);
      check("guard_release_lat", n, 2);
      check("guard_release_owner", arb_state, 2'b00);

      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("async_rst", {rd_en, wr0_en, wr1_en, arb_state, busy, timeout_err}, 7'b0001100);
      model_reset();
      rd_req = 1'b0;
      #2 rst_n = 1'b1;

      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 31) == 0) rd_req = ~rd_req;
         if ($urandom_range(0, 15) == 0) wr0_req = ~wr0_req;
         if ($urandom_range(0, 15) == 0) wr1_req = ~wr1_req;
         rd_done  = ($urandom_range(0, 39) == 0);
         wr0_done = ($urandom_range(0, 39) == 0);
         wr1_done = ($urandom_range(0, 39) == 0);
         mcb_cmd_empty = ($urandom_range(0, 7) != 0);
         step();
      end
      rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
      rd_done = 1'b0; wr0_done = 1'b0; wr1_done = 1'b0;
      mcb_cmd_empty = 1'b1;
      repeat (5) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
